// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, FSM state encoding and op-class helpers. Option macro: MDU_MADD_EN.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 5;

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_long_op(input mdu_op_e op);
    logic long_op;
    long_op = (op == OP_MULT) || (op == OP_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
    long_op = long_op || (op == OP_MADD) || (op == OP_MADDU) ||
              (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return long_op;
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational 64-bit HI:LO result generator for the MDU, including the
// divide-by-zero hold flag. Option macro: MDU_MADD_EN (multiply-accumulate ops).
module e_mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        hold
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  assign prod_s = 64'($signed(src_a)) * 64'($signed(src_b));
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // without relying on signed-overflow behaviour of the operator.
  assign abs_a = src_a[31] ? (~src_a + 32'd1) : src_a;
  assign abs_b = src_b[31] ? (~src_b + 32'd1) : src_b;
  assign div_b = (src_b == 32'd0) ? 32'd1 : src_b;
  assign q_mag = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
  assign r_mag = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
  assign quo_s = (src_a[31] ^ src_b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s = src_a[31] ? (~r_mag + 32'd1) : r_mag;
  assign quo_u = src_a / div_b;
  assign rem_u = src_a % div_b;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result = {hi, lo};
    hold   = 1'b0;
    unique case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {rem_s, quo_s};
      OP_DIVU:  result = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + prod_s;
      OP_MADDU: result = {hi, lo} + prod_u;
      OP_MSUB:  result = {hi, lo} - prod_s;
      OP_MSUBU: result = {hi, lo} - prod_u;
`endif
      default:  result = {hi, lo};
    endcase
    if (is_div_op(op) && (src_b == 32'd0)) begin
      result = {hi, lo};
      hold   = 1'b1;
    end
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: IDLE/RUN FSM, countdown counter, shadow and
// architectural HI/LO registers. Option macro: MDU_MADD_EN.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDU_Op,
  input  logic        E_Start,
  input  logic [31:0] E_SrcA,
  input  logic [31:0] E_SrcB,
  output logic        E_Busy,
  output logic        E_Start_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDU_Out
);

  mdu_op_e    op;
  mdu_state_e state_q;
  mdu_state_e state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] shadow_hi;
  logic [31:0] shadow_lo;
  logic        hold_q;
  logic [63:0] arith_result;
  logic        arith_hold;
  logic        start_long;
  logic        modify_op;
  logic        illegal_start;

  assign op            = mdu_op_e'(E_MDU_Op);
  assign modify_op     = is_long_op(op) || (op == OP_MTHI) || (op == OP_MTLO);
  assign start_long    = E_Start && is_long_op(op) && (state_q == ST_IDLE);
  assign illegal_start = E_Start && modify_op && (state_q == ST_RUN);

  e_mdu_arith u_arith (
    .op     (op),
    .src_a  (E_SrcA),
    .src_b  (E_SrcB),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_result),
    .hold   (arith_hold)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_long) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      hold_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (state_q == ST_IDLE) begin
      if (start_long) begin
        cnt_q     <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        shadow_hi <= arith_result[63:32];
        shadow_lo <= arith_result[31:0];
        hold_q    <= arith_hold;
      end else if (E_Start && (op == OP_MTHI)) begin
        hi_q <= E_SrcA;
      end else if (E_Start && (op == OP_MTLO)) begin
        lo_q <= E_SrcA;
      end
    end else begin
      cnt_q <= cnt_q - CNT_W'(1);
      // Divide by zero runs the full latency but leaves HI/LO untouched.
      if ((cnt_q == CNT_W'(1)) && !hold_q) begin
        hi_q <= shadow_hi;
        lo_q <= shadow_lo;
      end
    end
  end

  always_comb begin
    E_Busy       = (state_q == ST_RUN);
    E_Start_Busy = (E_Start && is_long_op(op)) || (state_q == ST_RUN);
    E_HI         = hi_q;
    E_LO         = lo_q;
    unique case (op)
      OP_MFHI: E_MDU_Out = hi_q;
      OP_MFLO: E_MDU_Out = lo_q;
      default: E_MDU_Out = 32'd0;
    endcase
  end

  // The hazard unit must never let a HI/LO-modifying op reach E while busy.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !illegal_start)
    else $error("e_mdu: HI/LO-modifying op issued while busy");

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: table of long-op vectors with a result
// scoreboard, plus sequences for reset-mid-run, illegal starts and E_Start=0.
module tb_e_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_MDU_Op;
  logic        E_Start;
  logic [31:0] E_SrcA;
  logic [31:0] E_SrcB;
  logic        E_Busy;
  logic        E_Start_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_MDU_Out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    string       name;
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [63:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[14];

  e_mdu dut (
    .clk          (clk),
    .reset        (reset),
    .E_MDU_Op     (E_MDU_Op),
    .E_Start      (E_Start),
    .E_SrcA       (E_SrcA),
    .E_SrcB       (E_SrcB),
    .E_Busy       (E_Busy),
    .E_Start_Busy (E_Start_Busy),
    .E_HI         (E_HI),
    .E_LO         (E_LO),
    .E_MDU_Out    (E_MDU_Out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic write_reg(input mdu_op_e op, input logic [31:0] v);
    @(negedge clk);
    E_MDU_Op = op; E_SrcA = v; E_Start = 1'b1;
    @(negedge clk);
    E_Start = 1'b0; E_MDU_Op = OP_NONE;
    check("mtx no busy", {63'd0, E_Busy}, 64'd0);
    check("mtx value", (op == OP_MTHI) ? {32'd0, E_HI} : {32'd0, E_LO}, {32'd0, v});
  endtask

  task automatic run_long(input string name, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [63:0] exp);
    int n;
    int sb_bad;
    logic [63:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    E_MDU_Op = op; E_SrcA = a; E_SrcB = b; E_Start = 1'b1;
    #1;
    check({name, " start_busy"}, {63'd0, E_Start_Busy}, {63'd0, (cyc > 0)});
    @(negedge clk);
    E_Start = 1'b0; E_MDU_Op = OP_NONE;
    n = 0; sb_bad = 0;
    while (E_Busy && n < 100) begin
      n++;
      if (!E_Start_Busy) sb_bad++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 64'(n), 64'(cyc));
    check({name, " start_busy while busy"}, 64'(sb_bad), 64'd0);
    want = exp_q.pop_front();
    check({name, " hi:lo"}, {E_HI, E_LO}, want);
    E_MDU_Op = OP_MFHI; #1;
    check({name, " mfhi"}, {32'd0, E_MDU_Out}, {32'd0, want[63:32]});
    E_MDU_Op = OP_MFLO; #1;
    check({name, " mflo"}, {32'd0, E_MDU_Out}, {32'd0, want[31:0]});
    E_MDU_Op = OP_NONE;
  endtask

  initial begin
    int n;
    vecs[0]  = '{"mult -2*3",     OP_MULT,  32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  64'hFFFFFFFF_FFFFFFFA, 5};
    vecs[1]  = '{"divu 7/2",      OP_DIVU,  32'd7,        32'd2,        32'h0,  32'h0,  64'h00000001_00000003, 10};
    vecs[2]  = '{"div -7/2",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  64'hFFFFFFFF_FFFFFFFD, 10};
    vecs[3]  = '{"div by zero",   OP_DIV,   32'd9,        32'd0,        32'h11, 32'h22, 64'h00000011_00000022, 10};
    vecs[4]  = '{"div overflow",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h6,  64'h00000000_80000000, 10};
    vecs[5]  = '{"multu max",     OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  64'hFFFFFFFE_00000001, 5};
    vecs[6]  = '{"mult minsq",    OP_MULT,  32'h80000000, 32'h80000000, 32'h0,  32'h0,  64'h40000000_00000000, 5};
    vecs[7]  = '{"divu big/16",   OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0,  32'h0,  64'h0000000F_0FFFFFFF, 10};
    vecs[8]  = '{"div 7/-2",      OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  64'h00000001_FFFFFFFD, 10};
    vecs[9]  = '{"divu by zero",  OP_DIVU,  32'd5,        32'd0,        32'hAA, 32'hBB, 64'h000000AA_000000BB, 10};
`ifdef MDU_MADD_EN
    vecs[10] = '{"maddu 1*1",     OP_MADDU, 32'd1,        32'd1,        32'h0,  32'hFFFFFFFF, 64'h00000001_00000000, 5};
    vecs[11] = '{"madd -1*2",     OP_MADD,  32'hFFFFFFFF, 32'd2,        32'h0,  32'h5,  64'h00000000_00000003, 5};
    vecs[12] = '{"msub 2*3",      OP_MSUB,  32'd2,        32'd3,        32'h0,  32'h0,  64'hFFFFFFFF_FFFFFFFA, 5};
    vecs[13] = '{"msubu 1*1",     OP_MSUBU, 32'd1,        32'd1,        32'h1,  32'h0,  64'h00000000_FFFFFFFF, 5};
`else
    vecs[10] = '{"maddu off",     OP_MADDU, 32'd1,        32'd1,        32'h0,  32'hFFFFFFFF, 64'h00000000_FFFFFFFF, 0};
    vecs[11] = '{"madd off",      OP_MADD,  32'hFFFFFFFF, 32'd2,        32'h0,  32'h5,  64'h00000000_00000005, 0};
    vecs[12] = '{"msub off",      OP_MSUB,  32'd2,        32'd3,        32'h0,  32'h0,  64'h00000000_00000000, 0};
    vecs[13] = '{"msubu off",     OP_MSUBU, 32'd1,        32'd1,        32'h1,  32'h0,  64'h00000001_00000000, 0};
`endif

    reset = 1'b1; E_MDU_Op = OP_NONE; E_Start = 1'b0; E_SrcA = '0; E_SrcB = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {63'd0, E_Busy}, 64'd0);
    check("reset start_busy", {63'd0, E_Start_Busy}, 64'd0);
    check("reset hi:lo", {E_HI, E_LO}, 64'd0);
    check("reset out", {32'd0, E_MDU_Out}, 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      write_reg(OP_MTHI, vecs[i].pre_hi);
      write_reg(OP_MTLO, vecs[i].pre_lo);
      run_long(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].exp);
    end

    // Asynchronous reset during busy cycle 3 of a divu.
    write_reg(OP_MTHI, 32'h55);
    write_reg(OP_MTLO, 32'h66);
    @(negedge clk);
    E_MDU_Op = OP_DIVU; E_SrcA = 32'd100; E_SrcB = 32'd7; E_Start = 1'b1;
    @(negedge clk);
    E_Start = 1'b0; E_MDU_Op = OP_NONE;
    repeat (2) @(negedge clk);
    check("pre-reset busy", {63'd0, E_Busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async reset busy", {63'd0, E_Busy}, 64'd0);
    check("async reset hi:lo", {E_HI, E_LO}, 64'd0);
    #1 reset = 1'b0;
    run_long("multu after reset", OP_MULTU, 32'hFFFFFFFF, 32'd2, 5, 64'h00000001_FFFFFFFE);

    // Illegal starts while busy are ignored; the assertion is expected to fire here.
    write_reg(OP_MTHI, 32'h0);
    write_reg(OP_MTLO, 32'h0);
    $assertoff;
    @(negedge clk);
    E_MDU_Op = OP_MULT; E_SrcA = 32'd3; E_SrcB = 32'd4; E_Start = 1'b1;
    @(negedge clk);
    E_Start = 1'b0; E_MDU_Op = OP_NONE;
    n = 0;
    while (E_Busy && n < 100) begin
      n++;
      if (n == 2) begin
        E_MDU_Op = OP_MULT; E_SrcA = 32'd5; E_SrcB = 32'd6; E_Start = 1'b1; #1;
        check("illegal mult start_busy", {63'd0, E_Start_Busy}, 64'd1);
        check("illegal mult flagged", {63'd0, dut.illegal_start}, 64'd1);
      end else if (n == 3) begin
        E_MDU_Op = OP_MTHI; E_SrcA = 32'hDEAD; E_Start = 1'b1; #1;
        check("illegal mthi flagged", {63'd0, dut.illegal_start}, 64'd1);
      end else begin
        E_Start = 1'b0; E_MDU_Op = OP_NONE;
      end
      @(negedge clk);
    end
    E_Start = 1'b0; E_MDU_Op = OP_NONE;
    check("illegal busy cycles", 64'(n), 64'd5);
    check("illegal hi:lo", {E_HI, E_LO}, 64'h00000000_0000000C);
    @(negedge clk);
    $asserton;

    // E_Start=0 leaves everything untouched regardless of op.
    E_MDU_Op = OP_MULT; E_SrcA = 32'd7; E_SrcB = 32'd7; #1;
    check("nostart start_busy", {63'd0, E_Start_Busy}, 64'd0);
    @(negedge clk);
    E_MDU_Op = OP_MTHI;
    @(negedge clk);
    E_MDU_Op = OP_NONE;
    check("nostart busy", {63'd0, E_Busy}, 64'd0);
    check("nostart hi:lo", {E_HI, E_LO}, 64'h00000000_0000000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the next-generation 5-stage MIPS pipeline (P6 instruction set).
- Implements mult, multu, div, divu, mthi, mtlo, mfhi and mflo against private HI/LO registers.
- Multiply and divide have parametrised multi-cycle latency. Busy status goes to the hazard unit, which stalls MDU-dependent instructions in D.
- Sits beside E_ALU. Its read result joins the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, cycles busy is high after a mult/multu start; legal range 1..31.
- DIV_CYCLES, 10, cycles busy is high after a div/divu start; legal range 1..31.
- CNT_W, 5, width of the internal countdown counter; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- E_MDU_Op  in  4  operation code from the shared package: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO (plus MADD/MADDU/MSUB/MSUBU under the option).
- E_Start  in  1  one-cycle qualifier: the instruction in E is valid and not bubbled. Gates all HI/LO-modifying ops.
- E_SrcA  in  32  forwarded rs value.
- E_SrcB  in  32  forwarded rt value.
- E_Busy  out  1  high while an operation is in progress.
- E_Start_Busy  out  1  combinational: E_Start and op is mult/div class, or E_Busy. Used by the hazard unit.
- E_HI  out  32  architectural HI.
- E_LO  out  32  architectural LO.
- E_MDU_Out  out  32  combinational: HI when op=MFHI, LO when op=MFLO, else 0.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: HI=0, LO=0, E_Busy=0, counter=0, state=IDLE, shadow result registers=0.
- Two states, IDLE and RUN.
- IDLE, E_Start=1, op in {MULT,MULTU,DIV,DIVU}:
  - Compute the 64-bit result from E_SrcA/E_SrcB and latch it into shadow_hi/shadow_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES as appropriate, and go to RUN.
  - E_Busy rises the next cycle.
- RUN:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, HI/LO are loaded from the shadow registers at the clock edge, and state returns to IDLE.
  - E_Busy is therefore high for exactly N cycles. The new HI/LO are visible in the first cycle E_Busy is low.
- MTHI/MTLO with E_Start=1 in IDLE: HI or LO is written with E_SrcA at the next edge, with no busy period.
- MFHI/MFLO: pure combinational read of the current HI/LO. The hazard unit guarantees they never issue while E_Start_Busy=1.
- Start of any HI/LO-modifying op while E_Busy=1: ignored, with no state change. Flag it as a simulation assertion error, because the hazard unit must prevent it.
- E_Start=0: no state change, whatever the value of E_MDU_Op.
- mult: signed 32x32→64. multu: unsigned. In both, HI gets the upper 32 bits and LO the lower 32.
- div: signed. LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
- divu: unsigned division.
- Divide by zero (E_SrcB=0): the operation still takes DIV_CYCLES with busy high, but HI/LO stay unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
- Reset asserted mid-RUN: immediate return to IDLE, E_Busy=0, HI=LO=0, shadow registers discarded.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Adds MADD/MADDU/MSUB/MSUBU.
  - At start, shadow = {HI,LO} ± the 64-bit signed or unsigned product; this is wrap-around 64-bit arithmetic.
  - Latency is MULT_CYCLES.
  - The products are taken from the same issue-time HI/LO that the ± uses.
- Undefined: these op codes behave as NONE. No HI/LO change, no busy.

Decomposition:
- Package mdu_pkg holds:
  - the MDU_Op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12);
  - default latency constants;
  - the state encoding.
- Sub-module mdu_arith: purely combinational 64-bit result generator, including the divide-by-zero hold flag. e_mdu holds the FSM, counter and registers.

Test Plan:
1. mult with E_SrcA=0xFFFFFFFE (-2), E_SrcB=3, start pulse → E_Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. divu with 7/2, then div with 0xFFFFFFF9 (-7)/2 → after 10 busy cycles each: HI=1, LO=3, then HI=0xFFFFFFFF, LO=0xFFFFFFFD.
3. div by zero with HI=0x11, LO=0x22 preloaded via mthi/mtlo → 10 busy cycles, then HI=0x11, LO=0x22; also div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
4. Reset asserted at busy cycle 3 of a divu → E_Busy=0, HI=LO=0 asynchronously; a new multu 0xFFFFFFFF*2 then gives HI=1, LO=0xFFFFFFFE.
5. Second mult started while busy, and mthi while busy → ignored, assertion fired; HI/LO reflect only the first op. E_Start_Busy is high during the start cycle and all busy cycles.
6. With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu with 1*1 → HI=1, LO=0. Without the macro: same stimulus → no change, E_Busy stays 0.
